// File: rtl/fifo_serial_tx_if.sv
// Bundles the FIFO read port and the serial line side of fifo_serial_tx.
// Ready/valid meaning of the FIFO side: the head byte on i_data is valid
// whenever i_empty is low, and a single-cycle high on o_rd consumes it at
// the next rising clock edge. o_rd is never high while i_empty is high.
// The master modport is the FIFO/board side; the slave modport is the
// transmitter.
interface fifo_serial_tx_if;
  logic       i_empty;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_tx;
  logic       o_busy;

  modport master (
    output i_empty,
    output i_data,
    input  o_rd,
    input  o_tx,
    input  o_busy
  );

  modport slave (
    input  i_empty,
    input  i_data,
    output o_rd,
    output o_tx,
    output o_busy
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pulls bytes from a first-word-fall-through FIFO and sends
// them as asynchronous serial frames, LSB first, at CLK_FREQ/BAUD_RATE
// clocks per bit. Default frame is 8N1.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit (8E1).
// o_dbg_state exposes the FSM state for checkers:
//   0 IDLE, 1 START, 2 DATA, 3 STOP, 4 PARITY.
module fifo_serial_tx #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  fifo_serial_tx_if.slave  bus,
  output logic [2:0]       o_dbg_state
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  // A divider below 2 cannot form a bit period; refuse to elaborate.
  generate
    if (BAUD_DIV < 2) begin : g_bad_baud_div
      $error("fifo_serial_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef FIFO_SERIAL_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             rd_c;
  logic             bit_end;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state, baud counting, byte loading and the pop strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rd_c      = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // The counter free-runs through every bit of a frame and wraps at the
    // bit end; IDLE holds it at zero so a new frame starts phase-aligned.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.i_empty) begin
          rd_c     = 1'b1;
          shift_d  = bus.i_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          parity_d = ^bus.i_data;
`endif
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Last stop cycle is the second pop point: chaining straight into
        // START keeps the line continuous between back-to-back bytes.
        if (bit_end) begin
          if (!bus.i_empty) begin
            rd_c     = 1'b1;
            shift_d  = bus.i_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_d = ^bus.i_data;
`endif
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and busy flag are derived from the upcoming state so the
  // registered outputs change on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset forces the line idle at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // The pop strobe is gated by reset: while reset is held the FSM sits in
  // IDLE, and a non-empty FIFO must not be drained until release.
  assign bus.o_rd    = rd_c & i_rst_n;
  assign bus.o_tx    = tx_q;
  assign bus.o_busy  = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with CLK_FREQ=4, BAUD_RATE=1 (4 clocks
// per bit). A queue-based FIFO model feeds the DUT; every byte written is
// also pushed to exp_q, and a line monitor pops exp_q at each frame start
// and checks the line level and busy flag on every cycle of the frame.
// Define FIFO_SERIAL_TX_PARITY_EN for both RTL and bench to test 8E1.
module tb_fifo_serial_tx;

  localparam int BAUD_DIV = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME  = NBITS * BAUD_DIV;
  localparam int BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  fifo_serial_tx_if bus ();

  fifo_serial_tx #(
    .CLK_FREQ  (4),
    .BAUD_RATE (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         rd_count = 0;
  int         busy_cycles = 0;
  int         frames_done = 0;
  int         aborted = 0;
  logic       rd_seen;
  bit         mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and pop sampling at the active edge (pre-update values).
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_seen <= 1'b0;
    end else begin
      rd_seen <= bus.o_rd;
      if (bus.o_rd) begin
        rd_count <= rd_count + 1;
        pop_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- FIFO model (sole driver of i_empty / i_data) --------
  initial begin
    bus.i_empty = 1'b1;
    bus.i_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_seen) begin
        chk("rd_while_empty", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
      bus.i_empty = (fifo_q.size() == 0);
      bus.i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) busy_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    wr_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && wr_q.size() == 0 && fifo_q.size() == 0 &&
          !mon_busy && bus.o_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_pop(input int target, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (rd_count >= target) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_pop_timeout"}, 32'(done), 32'd1);
  endtask

  // ---------------- scoreboard / line monitor ----------------
  task run_frame();
    logic [7:0]       b;
    logic [NBITS-1:0] bits;
    bit               ab;
    mon_busy = 1'b1;
    ab       = 1'b0;
    chk("exp_q_has_byte", 32'(exp_q.size() != 0), 32'd1);
    b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (rst_n !== 1'b1) begin
        ab = 1'b1;
        break;
      end
      chk($sformatf("tx_%02h_bit%0d", b, i / BAUD_DIV), 32'(bus.o_tx), 32'(bits[i / BAUD_DIV]));
      chk($sformatf("busy_%02h_cyc%0d", b, i), 32'(bus.o_busy), 32'd1);
    end
    if (ab) aborted++;
    else    frames_done++;
    mon_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rd_seen === 1'b1 && rst_n === 1'b1) run_frame();
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int r0, b0, f0, a0, p0;

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(bus.o_tx), 32'd1);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_rd", 32'(bus.o_rd), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Empty FIFO: line stays idle for 200 cycles.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_rd", 32'(bus.o_rd), 32'd0);
      chk("idle_tx", 32'(bus.o_tx), 32'd1);
      chk("idle_busy", 32'(bus.o_busy), 32'd0);
    end

    // Single byte 0x41.
    r0 = rd_count; b0 = busy_cycles; f0 = frames_done;
    #1 push(8'h41);
    wait_idle("single");
    chk("single_rd_pulses", 32'(rd_count - r0), 32'd1);
    chk("single_busy_cycles", 32'(busy_cycles - b0), 32'(FRAME));
    chk("single_frames", 32'(frames_done - f0), 32'd1);
    chk("single_state_idle", 32'(dbg_state), 32'd0);
    chk("single_tx_idle", 32'(bus.o_tx), 32'd1);

    // Three preloaded bytes sent back to back.
    r0 = rd_count; b0 = busy_cycles; f0 = frames_done; p0 = pop_cyc.size();
    @(negedge clk);
    #1 push(8'h40); push(8'h41); push(8'h42);
    wait_idle("b2b");
    chk("b2b_rd_pulses", 32'(rd_count - r0), 32'd3);
    chk("b2b_frames", 32'(frames_done - f0), 32'd3);
    chk("b2b_busy_cycles", 32'(busy_cycles - b0), 32'(3 * FRAME));
    if (pop_cyc.size() >= p0 + 3) begin
      chk("b2b_gap1", 32'(pop_cyc[p0 + 1] - pop_cyc[p0]), 32'(FRAME));
      chk("b2b_gap2", 32'(pop_cyc[p0 + 2] - pop_cyc[p0 + 1]), 32'(FRAME));
    end

    // Parity-relevant byte 0x43 (odd popcount) as a single frame.
    b0 = busy_cycles; f0 = frames_done;
    @(negedge clk);
    #1 push(8'h43);
    wait_idle("byte43");
    chk("byte43_frames", 32'(frames_done - f0), 32'd1);
    chk("byte43_busy_cycles", 32'(busy_cycles - b0), 32'(FRAME));

    // Byte written into an empty FIFO during the stop bit of a frame.
    r0 = rd_count; f0 = frames_done; p0 = pop_cyc.size();
    @(negedge clk);
    #1 push(8'h3C);
    wait_pop(r0 + 1, "late");
    repeat (FRAME - 4) @(negedge clk);
    chk("late_fifo_empty_in_stop", 32'(bus.i_empty), 32'd1);
    chk("late_in_stop_state", 32'(dbg_state), 32'd3);
    #1 push(8'hC3);
    wait_idle("late");
    chk("late_rd_pulses", 32'(rd_count - r0), 32'd2);
    chk("late_frames", 32'(frames_done - f0), 32'd2);
    if (pop_cyc.size() >= p0 + 2)
      chk("late_gap", 32'(pop_cyc[p0 + 1] - pop_cyc[p0]), 32'(FRAME));

    // Reset during data bit 3 of 0x55; 0x56 waits in the FIFO.
    r0 = rd_count; f0 = frames_done; a0 = aborted;
    @(negedge clk);
    #1 push(8'h55);
    wait_pop(r0 + 1, "rst");
    #1 push(8'h56);
    repeat (16) @(negedge clk);
    chk("rst_in_data_state", 32'(dbg_state), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_immediate", 32'(bus.o_tx), 32'd1);
    chk("rst_busy_immediate", 32'(bus.o_busy), 32'd0);
    chk("rst_state_immediate", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_rd", 32'(bus.o_rd), 32'd0);
      chk("rst_hold_tx", 32'(bus.o_tx), 32'd1);
    end
    chk("rst_fifo_kept_56", 32'(bus.i_data), 32'h56);
    chk("rst_frame_aborted", 32'(aborted - a0), 32'd1);
    #1 rst_n = 1'b1;
    wait_idle("rst");
    chk("rst_rd_pulses", 32'(rd_count - r0), 32'd2);
    chk("rst_frames", 32'(frames_done - f0), 32'd1);
    chk("rst_final_tx", 32'(bus.o_tx), 32'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
